// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one external combinational RV64 ALU between two requesters.
//   Requests are arbitrated round-robin, the winning operands are registered
//   onto the alu_* bus, the ALU result is captured one cycle later and held
//   on a single response port (tagged with the requester ID) until accepted.
//   funct3/funct7 are passed through untouched.
//
// Ports
//   clk, rst_n                : rising-edge clock, async active-low reset
//   reqN_valid / reqN_ready   : requester N handshake (N = 0, 1)
//   reqN_funct3/funct7/rs1/rs2: requester N operation, sampled at accept only
//   alu_funct3/funct7/rs1/rs2 : registered operands driven to the ALU
//   alu_rd                    : ALU result (combinational from alu_*)
//   resp_valid / resp_ready   : response handshake
//   resp_id, resp_rd          : requester tag and result of the response
//   busy                      : an operation is in flight
//   done_cnt0/1               : delivered responses per requester (wrapping)

module alu_arbiter #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_funct3,
  input  logic [6:0]       req0_funct7,
  input  logic [XLEN-1:0]  req0_rs1,
  input  logic [XLEN-1:0]  req0_rs2,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_funct3,
  input  logic [6:0]       req1_funct7,
  input  logic [XLEN-1:0]  req1_rs1,
  input  logic [XLEN-1:0]  req1_rs2,

  output logic [2:0]       alu_funct3,
  output logic [6:0]       alu_funct7,
  output logic [XLEN-1:0]  alu_rs1,
  output logic [XLEN-1:0]  alu_rs2,
  input  logic [XLEN-1:0]  alu_rd,

  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [XLEN-1:0]  resp_rd,

  output logic             busy,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q,      state_d;
  logic              last_grant_q, last_grant_d;
  logic [2:0]        alu_funct3_q, alu_funct3_d;
  logic [6:0]        alu_funct7_q, alu_funct7_d;
  logic [XLEN-1:0]   alu_rs1_q,    alu_rs1_d;
  logic [XLEN-1:0]   alu_rs2_q,    alu_rs2_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q,    resp_id_d;
  logic [XLEN-1:0]   resp_rd_q,    resp_rd_d;
  logic [CNT_W-1:0]  done_cnt0_q,  done_cnt0_d;
  logic [CNT_W-1:0]  done_cnt1_q,  done_cnt1_d;

  logic grant_id;
  logic accept;

  // Round-robin pick: under contention the requester that did not win last
  // time is chosen; otherwise whichever one is valid.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // rst_n gates ready so nothing is offered while reset is held, even though
  // the state register already reads IDLE.
  assign accept     = rst_n && (state_q == S_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept &&  grant_id;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_funct3_d = alu_funct3_q;
    alu_funct7_d = alu_funct7_q;
    alu_rs1_d    = alu_rs1_q;
    alu_rs2_d    = alu_rs2_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_rd_d    = resp_rd_q;
    done_cnt0_d  = done_cnt0_q;
    done_cnt1_d  = done_cnt1_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d      = S_EXEC;
          last_grant_d = grant_id;
          if (grant_id) begin
            alu_funct3_d = req1_funct3;
            alu_funct7_d = req1_funct7;
            alu_rs1_d    = req1_rs1;
            alu_rs2_d    = req1_rs2;
          end else begin
            alu_funct3_d = req0_funct3;
            alu_funct7_d = req0_funct7;
            alu_rs1_d    = req0_rs1;
            alu_rs2_d    = req0_rs2;
          end
        end
      end

      S_EXEC: begin
        // last_grant_q was loaded with the accepted requester's ID, so it
        // doubles as the in-flight tag.
        resp_rd_d    = alu_rd;
        resp_id_d    = last_grant_q;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end

      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
          if (resp_id_q) begin
            done_cnt1_d = done_cnt1_q + CNT_W'(1);
          end else begin
            done_cnt0_d = done_cnt0_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      alu_funct3_q <= '0;
      alu_funct7_q <= '0;
      alu_rs1_q    <= '0;
      alu_rs2_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_rd_q    <= '0;
      done_cnt0_q  <= '0;
      done_cnt1_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_funct3_q <= alu_funct3_d;
      alu_funct7_q <= alu_funct7_d;
      alu_rs1_q    <= alu_rs1_d;
      alu_rs2_q    <= alu_rs2_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_rd_q    <= resp_rd_d;
      done_cnt0_q  <= done_cnt0_d;
      done_cnt1_q  <= done_cnt1_d;
    end
  end

  assign alu_funct3 = alu_funct3_q;
  assign alu_funct7 = alu_funct7_q;
  assign alu_rs1    = alu_rs1_q;
  assign alu_rs2    = alu_rs2_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_rd    = resp_rd_q;
  assign busy       = (state_q != S_IDLE);
  assign done_cnt0  = done_cnt0_q;
  assign done_cnt1  = done_cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. Provides an RV64 ALU on the alu_* bus and
// checks sequencing, arbitration, backpressure, operand capture, reset
// abort and counter wrap (narrow counters) against expectations built here.

module tb_alu_arbiter;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req0_ready;
  logic [2:0]       req0_funct3;
  logic [6:0]       req0_funct7;
  logic [XLEN-1:0]  req0_rs1, req0_rs2;
  logic             req1_valid, req1_ready;
  logic [2:0]       req1_funct3;
  logic [6:0]       req1_funct7;
  logic [XLEN-1:0]  req1_rs1, req1_rs2;
  logic [2:0]       alu_funct3;
  logic [6:0]       alu_funct7;
  logic [XLEN-1:0]  alu_rs1, alu_rs2, alu_rd;
  logic             resp_valid, resp_ready, resp_id;
  logic [XLEN-1:0]  resp_rd;
  logic             busy;
  logic [CNT_W-1:0] done_cnt0, done_cnt1;

  int n_run  = 0;
  int n_fail = 0;
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;

  alu_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_funct3(req0_funct3), .req0_funct7(req0_funct7),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_funct3(req1_funct3), .req1_funct7(req1_funct7),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_rd(resp_rd),
    .busy(busy), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV64 OP-class integer ALU
  function automatic logic [63:0] alu_ref(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    case (f3)
      3'd0: r = f7[5] ? a - b : a + b;
      3'd1: r = a << b[5:0];
      3'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd3: r = (a < b) ? 64'd1 : 64'd0;
      3'd4: r = a ^ b;
      3'd5: r = f7[5] ? 64'($signed(a) >>> b[5:0]) : a >> b[5:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  assign alu_rd = alu_ref(alu_funct3, alu_funct7, alu_rs1, alu_rs2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [6:0] rand_f7();
    int unsigned k;
    k = $urandom_range(0, 4);
    if (k == 0) return 7'($urandom);
    return (k < 3) ? 7'h00 : 7'h20;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    req0_funct3 = 3'd0; req0_funct7 = 7'd0; req0_rs1 = 64'd1; req0_rs2 = 64'd2;
    req1_funct3 = 3'd0; req1_funct7 = 7'd0; req1_rs1 = 64'd3; req1_rs2 = 64'd4;
    #3;
    n_run++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++;
      $display("FAIL reset_ready: got %b%b exp 00", req0_ready, req1_ready); end
    n_run++; if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_id !== 1'b0) begin n_fail++;
      $display("FAIL reset_ctl: got valid=%b busy=%b id=%b exp 0 0 0", resp_valid, busy, resp_id); end
    n_run++; if (resp_rd !== 64'd0 || alu_rs1 !== 64'd0 || alu_rs2 !== 64'd0 ||
                 alu_funct3 !== 3'd0 || alu_funct7 !== 7'd0) begin n_fail++;
      $display("FAIL reset_data: got rd=%h rs1=%h rs2=%h exp all zero", resp_rd, alu_rs1, alu_rs2); end
    n_run++; if (done_cnt0 !== '0 || done_cnt1 !== '0) begin n_fail++;
      $display("FAIL reset_cnt: got %0d/%0d exp 0/0", done_cnt0, done_cnt1); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_funct3 = 3'b000; req0_funct7 = 7'b0000000;
    req0_rs1 = 64'd5; req0_rs2 = 64'd7;
    #1;
    n_run++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++;
      $display("FAIL add_ready: got %b%b exp 10", req0_ready, req1_ready); end
    tick(); req0_valid = 1'b0; #1;
    n_run++; if (busy !== 1'b1 || resp_valid !== 1'b0 || alu_rs1 !== 64'd5) begin n_fail++;
      $display("FAIL add_exec: got busy=%b valid=%b rs1=%h exp 1 0 5", busy, resp_valid, alu_rs1); end
    tick();
    n_run++; if (resp_valid !== 1'b1 || resp_rd !== 64'h000000000000000C || resp_id !== 1'b0) begin n_fail++;
      $display("FAIL add_resp: got valid=%b rd=%h id=%b exp 1 000000000000000c 0", resp_valid, resp_rd, resp_id); end
    tick(); exp_cnt0++;
    n_run++; if (resp_valid !== 1'b0 || busy !== 1'b0 || done_cnt0 !== CNT_W'(exp_cnt0)) begin n_fail++;
      $display("FAIL add_done: got valid=%b busy=%b cnt0=%0d exp 0 0 %0d", resp_valid, busy, done_cnt0, exp_cnt0); end
  endtask

  task automatic test_sub();
    resp_ready = 1'b1;
    req1_valid = 1'b1; req1_funct3 = 3'b000; req1_funct7 = 7'b0100000;
    req1_rs1 = 64'd0; req1_rs2 = 64'd1;
    #1;
    n_run++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_fail++;
      $display("FAIL sub_ready: got %b%b exp 01", req0_ready, req1_ready); end
    tick(); req1_valid = 1'b0;
    tick();
    n_run++; if (resp_valid !== 1'b1 || resp_rd !== 64'hFFFFFFFFFFFFFFFF || resp_id !== 1'b1) begin n_fail++;
      $display("FAIL sub_resp: got valid=%b rd=%h id=%b exp 1 ffffffffffffffff 1", resp_valid, resp_rd, resp_id); end
    tick(); exp_cnt1++;
    n_run++; if (done_cnt1 !== CNT_W'(exp_cnt1) || done_cnt0 !== CNT_W'(exp_cnt0)) begin n_fail++;
      $display("FAIL sub_cnt: got %0d/%0d exp %0d/%0d", done_cnt0, done_cnt1, exp_cnt0, exp_cnt1); end
  endtask

  task automatic test_operand_stability();
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_funct3 = 3'b000; req0_funct7 = 7'd0;
    req0_rs1 = 64'd5; req0_rs2 = 64'd7;
    tick();
    req0_valid = 1'b0; req0_rs1 = 64'd9; req0_rs2 = rand64(); req0_funct7 = 7'h20;
    tick();
    n_run++; if (resp_valid !== 1'b1 || resp_rd !== 64'h000000000000000C) begin n_fail++;
      $display("FAIL stable_rd: got valid=%b rd=%h exp 1 000000000000000c", resp_valid, resp_rd); end
    tick(); exp_cnt0++;
    n_run++; if (done_cnt0 !== CNT_W'(exp_cnt0)) begin n_fail++;
      $display("FAIL stable_cnt: got %0d exp %0d", done_cnt0, exp_cnt0); end
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_funct3 = 3'b000; req0_funct7 = 7'd0;
    req0_rs1 = 64'd100; req0_rs2 = 64'd23;
    tick();
    req1_valid = 1'b1; req1_funct3 = 3'($urandom); req1_funct7 = rand_f7();
    req1_rs1 = rand64(); req1_rs2 = rand64();
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      n_run++; if (resp_valid !== 1'b1 || resp_rd !== 64'd123 || resp_id !== 1'b0) begin n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b rd=%h id=%b exp 1 7b 0", i, resp_valid, resp_rd, resp_id); end
      n_run++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin n_fail++;
        $display("FAIL bp_ready[%0d]: got rdy=%b%b busy=%b exp 00 1", i, req0_ready, req1_ready, busy); end
      tick();
    end
    resp_ready = 1'b1;
    tick(); exp_cnt0++;
    n_run++; if (resp_valid !== 1'b0 || busy !== 1'b0 || done_cnt0 !== CNT_W'(exp_cnt0)) begin n_fail++;
      $display("FAIL bp_release: got valid=%b busy=%b cnt0=%0d exp 0 0 %0d", resp_valid, busy, done_cnt0, exp_cnt0); end
    n_run++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_fail++;
      $display("FAIL bp_next_grant: got %b%b exp 01", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_exec();
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_funct3 = 3'd4; req0_rs1 = rand64(); req0_rs2 = rand64();
    tick();
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    n_run++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL rstx_state: got valid=%b busy=%b exp 0 0", resp_valid, busy); end
    n_run++; if (done_cnt0 !== '0 || done_cnt1 !== '0) begin n_fail++;
      $display("FAIL rstx_cnt: got %0d/%0d exp 0/0", done_cnt0, done_cnt1); end
    n_run++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++;
      $display("FAIL rstx_ready: got %b%b exp 00", req0_ready, req1_ready); end
    tick(); tick();
    n_run++; if (resp_valid !== 1'b0) begin n_fail++;
      $display("FAIL rstx_noresp: got %b exp 0", resp_valid); end
    rst_n = 1'b1;
    #1;
    n_run++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++;
      $display("FAIL rstx_first: got %b%b exp 10", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    exp_cnt0 = 0; exp_cnt1 = 0;
    tick();
  endtask

  task automatic test_contention();
    logic [63:0] want;
    logic        g;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 1);
      req0_funct3 = 3'($urandom); req0_funct7 = rand_f7(); req0_rs1 = rand64(); req0_rs2 = rand64();
      req1_funct3 = 3'($urandom); req1_funct7 = rand_f7(); req1_rs1 = rand64(); req1_rs2 = rand64();
      want = g ? alu_ref(req1_funct3, req1_funct7, req1_rs1, req1_rs2)
               : alu_ref(req0_funct3, req0_funct7, req0_rs1, req0_rs2);
      #1;
      n_run++; if (req0_ready !== !g || req1_ready !== g) begin n_fail++;
        $display("FAIL cont_grant[%0d]: got %b%b exp grant %0d", k, req0_ready, req1_ready, g); end
      tick();
      req0_rs1 = rand64(); req1_rs1 = rand64(); req0_funct3 = 3'($urandom); req1_funct3 = 3'($urandom);
      tick();
      n_run++; if (resp_valid !== 1'b1 || resp_id !== g || resp_rd !== want) begin n_fail++;
        $display("FAIL cont_resp[%0d]: got valid=%b id=%b rd=%h exp 1 %0d %h", k, resp_valid, resp_id, resp_rd, g, want); end
      tick();
      if (g) exp_cnt1++; else exp_cnt0++;
    end
    n_run++; if (done_cnt0 !== CNT_W'(2) || done_cnt1 !== CNT_W'(2)) begin n_fail++;
      $display("FAIL cont_cnt: got %0d/%0d exp 2/2", done_cnt0, done_cnt1); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  // Random traffic against a transaction-level reference: one operation in
  // flight at most, result appears one edge after accept, retires on the
  // first edge with resp_ready high, next accept only after that.
  task automatic test_random();
    logic        m_last;
    logic        m_busy;
    logic        m_resp_out;
    logic        m_id;
    logic [63:0] m_rd;
    logic        gv, g;
    int          m_cnt [2];
    rst_n = 1'b0; #1; rst_n = 1'b1;
    m_last = 1'b1; m_busy = 1'b0; m_resp_out = 1'b0; m_id = 1'b0; m_rd = '0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    tick();
    for (int c = 0; c < 400; c++) begin
      req0_valid = ($urandom_range(0, 2) != 0); req1_valid = ($urandom_range(0, 2) != 0);
      req0_funct3 = 3'($urandom); req0_funct7 = rand_f7(); req0_rs1 = rand64(); req0_rs2 = rand64();
      req1_funct3 = 3'($urandom); req1_funct7 = rand_f7(); req1_rs1 = rand64(); req1_rs2 = rand64();
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      gv = !m_busy && (req0_valid || req1_valid);
      g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
      n_run++; if (req0_ready !== (gv && !g) || req1_ready !== (gv && g)) begin n_fail++;
        $display("FAIL rnd_ready@%0d: got %b%b exp %b%b", c, req0_ready, req1_ready, gv && !g, gv && g); end
      n_run++; if (busy !== m_busy || resp_valid !== m_resp_out) begin n_fail++;
        $display("FAIL rnd_state@%0d: got busy=%b valid=%b exp %b %b", c, busy, resp_valid, m_busy, m_resp_out); end
      if (m_resp_out) begin
        n_run++; if (resp_id !== m_id || resp_rd !== m_rd) begin n_fail++;
          $display("FAIL rnd_resp@%0d: got id=%b rd=%h exp %b %h", c, resp_id, resp_rd, m_id, m_rd); end
      end
      n_run++; if (done_cnt0 !== CNT_W'(m_cnt[0]) || done_cnt1 !== CNT_W'(m_cnt[1])) begin n_fail++;
        $display("FAIL rnd_cnt@%0d: got %0d/%0d exp %0d/%0d", c, done_cnt0, done_cnt1,
                 m_cnt[0] % (1 << CNT_W), m_cnt[1] % (1 << CNT_W)); end
      if (gv) begin
        m_busy = 1'b1; m_id = g; m_last = g;
        m_rd = g ? alu_ref(req1_funct3, req1_funct7, req1_rs1, req1_rs2)
                 : alu_ref(req0_funct3, req0_funct7, req0_rs1, req0_rs2);
      end else if (m_busy && !m_resp_out) begin
        m_resp_out = 1'b1;
      end else if (m_resp_out && resp_ready) begin
        m_cnt[m_id] = m_cnt[m_id] + 1;
        m_resp_out = 1'b0; m_busy = 1'b0;
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_operand_stability();
    test_backpressure();
    test_reset_mid_exec();
    test_contention();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational 64-bit RV64 ALU between two requesters, e.g. the integer issue path and the address/branch path of the sequential core. Each requester presents funct3/funct7/rs1/rs2 over a valid/ready handshake. The block arbitrates round-robin, registers the operands into the ALU, captures rd, and returns it on a single response port tagged with the requester ID. The ALU's own encodings are passed through untouched; this block only sequences and arbitrates.

Parameters:
XLEN, 64, operand/result width
CNT_W, 32, width of per-requester completed-operation counters

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle (when valid)
req0_funct3  input  3  requester 0 funct3
req0_funct7  input  7  requester 0 funct7
req0_rs1  input  XLEN  requester 0 operand 1
req0_rs2  input  XLEN  requester 0 operand 2
req1_valid, req1_ready, req1_funct3, req1_funct7, req1_rs1, req1_rs2  same as requester 0, for requester 1
alu_funct3  output  3  to ALU
alu_funct7  output  7  to ALU
alu_rs1  output  XLEN  to ALU
alu_rs2  output  XLEN  to ALU
alu_rd  input  XLEN  ALU result (combinational from alu_* outputs)
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_id  output  1  requester that issued the result
resp_rd  output  XLEN  result
busy  output  1  state != IDLE
done_cnt0  output  CNT_W  responses delivered to requester 0
done_cnt1  output  CNT_W  responses delivered to requester 1

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=1 (so requester 0 wins first), all alu_* = 0, resp_valid=0, resp_id=0, resp_rd=0, done_cnt0/1=0. reqN_ready=0 while rst_n=0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: grant computed combinationally from valids and last_grant.
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - reqN_ready = (state==IDLE) & grant==N. Ready is never asserted to more than one requester.
  - On valid&ready: latch funct3/funct7/rs1/rs2 into alu_* registers, latch id, set last_grant=id, go to EXEC.
  - No valid: stay in IDLE; alu_* hold their previous values.
- EXEC (exactly 1 cycle): alu_* are stable from registers. At the clock edge: resp_rd <= alu_rd, resp_id <= latched id, resp_valid <= 1, go to RESP.
- RESP: resp_valid=1. resp_rd and resp_id held stable until resp_ready.
  - On resp_valid&resp_ready: resp_valid <= 0, increment done_cnt[resp_id], go to IDLE.
  - No new request is accepted in the same cycle (no bypass).
- Latency: accept at edge T; result visible at T+2; earliest next accept at the edge after the response handshake. Peak throughput is 1 op per 3 cycles.
- Counters wrap modulo 2^CNT_W without saturation.
- Requester inputs are sampled only at the accept edge. Later changes to the inputs have no effect on the in-flight operation.
- Dropping reqN_valid before ready: no grant, no state change, no error.
- Reset asserted during EXEC or RESP: the in-flight operation is discarded, no response is produced, counters are cleared.
- busy = (state != IDLE).

Test Plan:
- ADD via req0: funct3=000, funct7=0000000, rs1=5, rs2=7, resp_ready=1 -> req0_ready at T, resp_valid at T+2 with resp_rd=0x000000000000000C, resp_id=0, done_cnt0=1 after the handshake.
- SUB via req1: funct3=000, funct7=0100000, rs1=0, rs2=1 -> resp_rd=0xFFFFFFFFFFFFFFFF, resp_id=1.
- Contention: both valid continuously for 4 operations -> grant order 0,1,0,1; responses tagged 0,1,0,1; done_cnt0=done_cnt1=2.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_rd/resp_id constant, both readys low, busy=1. Raise resp_ready -> one handshake, return to IDLE, then next grant.
- Operand stability: change req0_rs1 from 5 to 9 one cycle after accept -> result still uses 5 (0xC for ADD with rs2=7).
- Reset mid-EXEC: pulse rst_n low during EXEC -> resp_valid stays 0, busy=0, counters 0. The next request is served first by requester 0 when both are valid.
